// File: rtl/bus_pkg.sv
// Shared definitions for the serial memory bus (master and slave sides).
package bus_pkg;

    localparam int unsigned ADDR_W_DEF  = 12;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned BURST_W_DEF = 4;
    localparam int unsigned TIMEOUT_DEF = 1024;

    // Burst field carries beats minus this offset.
    localparam int unsigned BURST_ENC_OFFSET = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RWAIT = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/shift_reg_piso_sipo.sv
// Shift register usable as PISO (load + shift out MSB) or SIPO (shift in LSB),
// with a bit counter that wraps every W shifts.
module shift_reg_piso_sipo #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         ser_in,
    output logic [W-1:0] par,
    output logic         ser_next_c,
    output logic         last_c,
    output logic         pre_last_c
);

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign par        = sr_q;
    assign last_c     = (cnt_q == CNT_W'(W - 1));
    assign pre_last_c = (cnt_q == CNT_W'(W - 2));

    // MSB that will be presented next cycle, so callers can register it.
    assign ser_next_c = load ? load_val[W-1] : (shift ? sr_q[W-2] : sr_q[W-1]);

    // Load has priority so a new word can be taken on the last shift of the old one.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_val;
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = {sr_q[W-2:0], ser_in};
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/master_port.sv
// Serial bus initiator: takes one parallel request, shifts address/burst/write
// data out MSB-first and assembles serial read data into bytes.
module master_port
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [BURST_W-1:0] req_burst,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_data_ack,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               done,
    output logic               err,
    output logic               busy,
    output logic               read_en,
    output logic               write_en,
    output logic               master_valid,
    output logic               master_ready,
    input  logic               slave_ready,
    input  logic               slave_valid,
    input  logic               slave_tx_done,
    output logic               tx_address,
    output logic               tx_burst,
    output logic               tx_data,
    input  logic               rx_data
);

    localparam int unsigned BEAT_W = BURST_W + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic                 write_q, write_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BURST_W-1:0]   burst_sh_q, burst_sh_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 out_en_q, out_en_d;
    logic                 wr_data_ack_q, wr_data_ack_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 read_en_q, read_en_d;
    logic                 write_en_q, write_en_d;
    logic                 master_valid_q, master_valid_d;
    logic                 master_ready_q, master_ready_d;
    logic                 tx_address_q, tx_address_d;
    logic                 tx_burst_q, tx_burst_d;
    logic                 tx_data_q, tx_data_d;

    logic                 accept;
    logic                 err_next;
    logic                 rx_take;
    logic                 last_beat;
    logic [BEAT_W-1:0]    beats_total;

    logic                 addr_load, addr_shift;
    logic [ADDR_W-1:0]    addr_par;
    logic                 addr_ser_next, addr_last, addr_pre_last;
    logic                 dat_load, dat_shift;
    logic [DATA_W-1:0]    dat_load_val, dat_par;
    logic                 dat_ser_next, dat_last, dat_pre_last;
    logic                 unused_addr_par;

    // Ready is held low until the first clock after reset release.
    assign req_ready = (state_q == ST_IDLE) && out_en_q;
    assign accept    = req_ready && req_valid;

    assign beats_total     = BEAT_W'(burst_q) + BEAT_W'(BURST_ENC_OFFSET);
    assign last_beat       = (beat_q == BEAT_W'(burst_q));
    assign unused_addr_par = ^addr_par;

    // Address path: loaded at accept, shifted out during ADDR.
    shift_reg_piso_sipo #(.W(ADDR_W)) u_addr_sr (
        .clk        (clk),
        .reset      (reset),
        .load       (addr_load),
        .load_val   (req_addr),
        .shift      (addr_shift),
        .ser_in     (1'b0),
        .par        (addr_par),
        .ser_next_c (addr_ser_next),
        .last_c     (addr_last),
        .pre_last_c (addr_pre_last)
    );

    // Data path: PISO for write bytes, SIPO for read bits.
    shift_reg_piso_sipo #(.W(DATA_W)) u_data_sr (
        .clk        (clk),
        .reset      (reset),
        .load       (dat_load),
        .load_val   (dat_load_val),
        .shift      (dat_shift),
        .ser_in     (rx_data),
        .par        (dat_par),
        .ser_next_c (dat_ser_next),
        .last_c     (dat_last),
        .pre_last_c (dat_pre_last)
    );

    // Next-state, datapath control and registered-output decode.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        burst_d      = burst_q;
        burst_sh_d   = burst_sh_q;
        beat_d       = beat_q;
        tmo_d        = tmo_q;
        out_en_d     = 1'b1;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        err_next     = 1'b0;
        addr_load    = 1'b0;
        addr_shift   = 1'b0;
        dat_load     = wr_data_ack_q;
        dat_load_val = wr_data;
        dat_shift    = 1'b0;
        rx_take      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_REQ;
                    write_d      = req_write;
                    burst_d      = req_burst;
                    burst_sh_d   = req_burst;
                    beat_d       = '0;
                    tmo_d        = '0;
                    addr_load    = 1'b1;
                    dat_load     = 1'b1;
                    dat_load_val = '0;
                end
            end
            ST_REQ: begin
                if (slave_ready) begin
                    state_d = ST_ADDR;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = ST_DONE;
                    err_next = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_ADDR: begin
                addr_shift = 1'b1;
                burst_sh_d = burst_sh_q << 1;
                if (addr_last) begin
                    state_d = write_q ? ST_WDATA : ST_RWAIT;
                    tmo_d   = '0;
                end
            end
            ST_WDATA: begin
                dat_shift = 1'b1;
                if (dat_last) begin
                    if (last_beat) state_d = ST_DONE;
                    else           beat_d  = beat_q + BEAT_W'(1);
                end
            end
            ST_RWAIT: begin
                rx_take = slave_valid && master_ready_q && (beat_q != beats_total);
                if (beat_q == beats_total) begin
                    // Final rd_valid cycle; done follows.
                    state_d = ST_DONE;
                end else if (slave_tx_done && !(rx_take && dat_last && last_beat)) begin
                    state_d  = ST_DONE;
                    err_next = 1'b1;
                end else if (rx_take) begin
                    dat_shift = 1'b1;
                    tmo_d     = '0;
                    if (dat_last) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = {dat_par[DATA_W-2:0], rx_data};
                        beat_d     = beat_q + BEAT_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = ST_DONE;
                    err_next = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d         = (state_d != ST_IDLE);
        write_en_d     = busy_d && write_d;
        read_en_d      = busy_d && !write_d;
        done_d         = (state_d == ST_DONE);
        err_d          = done_d && err_next;
        master_valid_d = (state_d == ST_REQ) || (state_d == ST_ADDR) || (state_d == ST_WDATA);
        master_ready_d = (state_d == ST_RWAIT);
        tx_address_d   = (state_d == ST_ADDR) && addr_ser_next;
        tx_burst_d     = (state_d == ST_ADDR) && burst_sh_d[BURST_W-1];
        tx_data_d      = (state_d == ST_WDATA) && dat_ser_next;
        wr_data_ack_d  = ((state_q == ST_ADDR) && write_q && addr_pre_last) ||
                         ((state_q == ST_WDATA) && dat_pre_last && !last_beat);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            write_q        <= 1'b0;
            burst_q        <= '0;
            burst_sh_q     <= '0;
            beat_q         <= '0;
            tmo_q          <= '0;
            out_en_q       <= 1'b0;
            wr_data_ack_q  <= 1'b0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            read_en_q      <= 1'b0;
            write_en_q     <= 1'b0;
            master_valid_q <= 1'b0;
            master_ready_q <= 1'b0;
            tx_address_q   <= 1'b0;
            tx_burst_q     <= 1'b0;
            tx_data_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            burst_q        <= burst_d;
            burst_sh_q     <= burst_sh_d;
            beat_q         <= beat_d;
            tmo_q          <= tmo_d;
            out_en_q       <= out_en_d;
            wr_data_ack_q  <= wr_data_ack_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            done_q         <= done_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            read_en_q      <= read_en_d;
            write_en_q     <= write_en_d;
            master_valid_q <= master_valid_d;
            master_ready_q <= master_ready_d;
            tx_address_q   <= tx_address_d;
            tx_burst_q     <= tx_burst_d;
            tx_data_q      <= tx_data_d;
        end
    end

    assign wr_data_ack  = wr_data_ack_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign done         = done_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign read_en      = read_en_q;
    assign write_en     = write_en_q;
    assign master_valid = master_valid_q;
    assign master_ready = master_ready_q;
    assign tx_address   = tx_address_q;
    assign tx_burst     = tx_burst_q;
    assign tx_data      = tx_data_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: table of write transactions plus
// hand-written read, timeout, early-termination and reset sequences.
module tb_master_port;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [3:0]  req_burst;
    logic [7:0]  wr_data;
    logic        wr_data_ack;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        busy;
    logic        read_en;
    logic        write_en;
    logic        master_valid;
    logic        master_ready;
    logic        slave_ready;
    logic        slave_valid;
    logic        slave_tx_done;
    logic        tx_address;
    logic        tx_burst;
    logic        tx_data;
    logic        rx_data;

    master_port #(.ADDR_W(12), .DATA_W(8), .BURST_W(4), .TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_burst     (req_burst),
        .wr_data       (wr_data),
        .wr_data_ack   (wr_data_ack),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .read_en       (read_en),
        .write_en      (write_en),
        .master_valid  (master_valid),
        .master_ready  (master_ready),
        .slave_ready   (slave_ready),
        .slave_valid   (slave_valid),
        .slave_tx_done (slave_tx_done),
        .tx_address    (tx_address),
        .tx_burst      (tx_burst),
        .tx_data       (tx_data),
        .rx_data       (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [3:0]  burst;
        logic [31:0] wdata;      // byte 0 in [31:24]
        logic [11:0] exp_a;      // tx_address over the 12 ADDR cycles
        logic [11:0] exp_b;      // tx_burst over the 12 ADDR cycles
        logic [31:0] exp_d;      // tx_data stream, first bit in [31]
        int          exp_done;   // done cycle relative to accept cycle
        int          exp_acks;
    } wvec_t;

    wvec_t wv [3];

    int checks;
    int errors;
    int rel;
    int rv_cnt;
    int done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({busy, write_en, read_en, master_valid, master_ready, tx_address,
                    tx_burst, tx_data, wr_data_ack, rd_valid, done, err, req_ready, rd_data});
    endfunction

    // Advance one cycle and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
        if (rd_valid) rv_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic issue_req(input logic w, input logic [11:0] a, input logic [3:0] b);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_burst = b;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        rel = 0;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rwait(output int entry);
        int n = 0;
        while (!master_ready && n < 40) begin
            tick();
            n++;
        end
        chk("rwait_reached", 32'(master_ready), 32'd1);
        entry = rel;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit txd_last);
        for (int j = 7; j >= 0; j--) begin
            if (gaps) begin
                int g = int'($urandom_range(0, 2));
                for (int k = 0; k < g; k++) begin
                    slave_valid = 1'b0;
                    tick();
                end
            end
            slave_valid   = 1'b1;
            rx_data       = b[j];
            slave_tx_done = txd_last && (j == 0);
            tick();
        end
        slave_valid   = 1'b0;
        rx_data       = 1'b0;
        slave_tx_done = 1'b0;
    endtask

    task automatic do_write(input int idx);
        wvec_t       v;
        logic [11:0] cap_a;
        logic [11:0] cap_b;
        logic [31:0] cap_d;
        int          nacks;
        int          nbits;
        int          dcyc;
        bit          seen;
        v     = wv[idx];
        cap_a = '0;
        cap_b = '0;
        cap_d = '0;
        nacks = 0;
        dcyc  = -1;
        seen  = 1'b0;
        nbits = 8 * (int'(v.burst) + 1);
        issue_req(1'b1, v.addr, v.burst);
        chk("w_write_en", 32'(write_en), 32'd1);
        chk("w_read_en", 32'(read_en), 32'd0);
        while (!seen && rel < 120) begin
            if (rel >= 2 && rel < 14) begin
                cap_a[13 - rel] = tx_address;
                cap_b[13 - rel] = tx_burst;
            end
            if (rel >= 14 && rel < 14 + nbits) cap_d[31 - (rel - 14)] = tx_data;
            if (wr_data_ack) begin
                chk("w_ack_cycle", 32'(rel), 32'(13 + 8 * nacks));
                if (nacks < 4) wr_data = v.wdata[31 - 8 * nacks -: 8];
                nacks++;
            end
            if (done) begin
                seen = 1'b1;
                dcyc = rel;
                chk("w_err", 32'(err), 32'd0);
                chk("w_busy_at_done", 32'(busy), 32'd1);
            end else begin
                tick();
            end
        end
        chk("w_done_seen", 32'(seen), 32'd1);
        chk("w_done_cycle", 32'(dcyc), 32'(v.exp_done));
        chk("w_ack_count", 32'(nacks), 32'(v.exp_acks));
        chk("w_tx_address", 32'(cap_a), 32'(v.exp_a));
        chk("w_tx_burst", 32'(cap_b), 32'(v.exp_b));
        chk("w_tx_data", cap_d, v.exp_d);
        tick();
        chk("w_idle_after", 32'({done, busy, write_en, req_ready}), 32'b0001);
    endtask

    initial begin
        int entry;
        int n;
        int rv0;
        checks        = 0;
        errors        = 0;
        rel           = 0;
        rv_cnt        = 0;
        done_cnt      = 0;
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_addr      = '0;
        req_burst     = '0;
        wr_data       = '0;
        slave_ready   = 1'b1;
        slave_valid   = 1'b0;
        slave_tx_done = 1'b0;
        rx_data       = 1'b0;

        wv[0] = '{12'h5A3, 4'd0, 32'hC400_0000, 12'b0101_1010_0011, 12'b0000_0000_0000,
                  32'b1100_0100_0000_0000_0000_0000_0000_0000, 22, 1};
        wv[1] = '{12'h9C1, 4'd3, 32'h1122_3344, 12'b1001_1100_0001, 12'b0011_0000_0000,
                  32'b0001_0001_0010_0010_0011_0011_0100_0100, 46, 4};
        wv[2] = '{12'hFFF, 4'd1, 32'hFF00_0000, 12'b1111_1111_1111, 12'b0001_0000_0000,
                  32'b1111_1111_0000_0000_0000_0000_0000_0000, 30, 2};

        // Reset values, and ready only after the first clock past release.
        #12;
        chk("reset_outputs", out_vec(), 32'd0);
        #10 reset = 1'b1;
        #1;
        chk("ready_before_clk", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_clk", 32'(req_ready), 32'd1);

        for (int i = 0; i < 3; i++) do_write(i);

        // Read burst 1 with random slave_valid gaps.
        rv0 = rv_cnt;
        issue_req(1'b0, 12'h123, 4'd1);
        chk("r_read_en", 32'({read_en, write_en}), 32'b10);
        wait_rwait(entry);
        chk("r_rwait_entry", 32'(entry), 32'd14);
        send_byte(8'hA5, 1'b1, 1'b0);
        chk("r_beat0", 32'({rd_valid, rd_data}), 32'h1A5);
        send_byte(8'h3C, 1'b1, 1'b0);
        chk("r_beat1", 32'({rd_valid, rd_data}), 32'h13C);
        chk("r_no_early_done", 32'(done), 32'd0);
        tick();
        chk("r_done", 32'({done, err}), 32'b10);
        tick();
        chk("r_rd_valid_count", 32'(rv_cnt - rv0), 32'd2);
        chk("r_idle", 32'({read_en, busy, req_ready}), 32'b001);

        // Slave never answers: timeout 16 cycles after entering RWAIT.
        issue_req(1'b0, 12'h0AA, 4'd0);
        wait_rwait(entry);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_delay", 32'(rel - entry), 32'd16);
        chk("tmo_done_err", 32'({done, err}), 32'b11);
        tick();

        // Burst 2 aborted by slave_tx_done after the first byte.
        rv0 = rv_cnt;
        issue_req(1'b0, 12'h7E0, 4'd2);
        wait_rwait(entry);
        send_byte(8'h5E, 1'b0, 1'b0);
        chk("early_beat0", 32'({rd_valid, rd_data}), 32'h15E);
        slave_tx_done = 1'b1;
        tick();
        slave_tx_done = 1'b0;
        chk("early_done_err", 32'({done, err}), 32'b11);
        tick();
        tick();
        chk("early_rd_valid_count", 32'(rv_cnt - rv0), 32'd1);

        // slave_tx_done on the final bit is a clean finish.
        issue_req(1'b0, 12'h001, 4'd0);
        wait_rwait(entry);
        send_byte(8'h81, 1'b1, 1'b1);
        chk("last_bit_txd_beat", 32'({rd_valid, rd_data}), 32'h181);
        tick();
        chk("last_bit_txd_done", 32'({done, err}), 32'b10);
        tick();

        // Asynchronous reset during WDATA, then a normal write.
        issue_req(1'b1, 12'h3C5, 4'd1);
        for (int k = 0; k < 17; k++) tick();
        chk("pre_reset_active", 32'({busy, master_valid}), 32'b11);
        n = done_cnt;
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", out_vec(), 32'd0);
        tick();
        #3 reset = 1'b1;
        tick();
        chk("reset_no_done", 32'(done_cnt - n), 32'd0);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        do_write(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
